song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//   Sequences the note ROMs feeding the tone generator: steps the ROM address at a
//   programmable tempo, selects the song, and supports play/pause/stop/loop.
//   Replaces the free-running tone[] address taps. Output fullnote drives the
//   divide-by-12 / clock-divider path directly; fullnote==0 means silence.
// PARAMETERS
//   TICK_DIV  8388608  cycles per ROM step at tempo 0 (2^23 @ 100 MHz)
//   LEN0      196      entries in song 0 (last valid address LEN0-1)
//   LEN1      243      entries in song 1 (last valid address LEN1-1)
//   ADDR_W    8        ROM address width
//   NOTE_W    8        note code width
// PORTS
//   CLK100MHZ  in   1       system clock, 100 MHz
//   rst_n      in   1       reset, asynchronous, active-low
//   play_p     in   1       one-cycle pulse (debounced upstream): start / pause / resume
//   stop_p     in   1       one-cycle pulse: abort to IDLE
//   song_sel   in   1       0=song 0, 1=song 1; sampled only when starting from IDLE
//   loop_en    in   1       1=restart at address 0 after last entry
//   tempo      in   2       step period = TICK_DIV >> tempo
//   rom_addr   out  ADDR_W  address to both note ROMs (registered)
//   rom_note0  in   NOTE_W  song 0 ROM data, 1-cycle registered latency
//   rom_note1  in   NOTE_W  song 1 ROM data, 1-cycle registered latency
//   fullnote   out  NOTE_W  note to tone generator (registered)
//   playing    out  1       1 in FETCH/PLAY
//   paused     out  1       1 in PAUSE
//   done_p     out  1       one-cycle pulse when a non-looping song ends
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, rom_addr=0, fullnote=0,
//     playing=0, paused=0, done_p=0, cur_song=0, step counter=0.
//   States: IDLE, FETCH, PLAY, PAUSE, DONE.
//   IDLE:  fullnote=0. play_p -> cur_song<=song_sel, rom_addr<=0, go FETCH.
//   FETCH: exactly 2 cycles (addr reg + ROM reg); fullnote holds previous value.
//     On 2nd cycle: fullnote<=(cur_song?rom_note1:rom_note0),
//     counter<=(TICK_DIV>>tempo)-1, go PLAY.
//   PLAY:  counter decrements each cycle; at counter==0:
//     rom_addr < LENx-1  -> rom_addr+1, go FETCH.
//     rom_addr==LENx-1 & loop_en -> rom_addr<=0, go FETCH.
//     rom_addr==LENx-1 & !loop_en -> go DONE.
//     PLAY lasts exactly TICK_DIV>>tempo cycles; a step is that +2 cycles.
//     tempo sampled only at FETCH->PLAY; mid-step changes take effect next step.
//   PAUSE: entered by play_p in PLAY or FETCH (FETCH completes its ROM read first,
//     then enters PAUSE instead of PLAY). fullnote=0, counter and rom_addr frozen.
//     play_p -> PLAY, fullnote restored from held note, counter resumes.
//   DONE:  fullnote<=0, done_p=1 for exactly one cycle, go IDLE.
//   stop_p in any state -> IDLE next cycle, rom_addr<=0, fullnote<=0; no done_p.
//   Priority same cycle: stop_p > play_p > counter expiry.
//   play_p in PLAY on the counter==0 cycle: pause wins, no advance; on resume,
//     expiry occurs on the first PLAY cycle.
//   rom_addr never exceeds LENx-1; song_sel changes while not IDLE are ignored.
//   Counter 32 bits; TICK_DIV>>tempo must be >=1 (TICK_DIV>=8 required).
// TESTING (TICK_DIV=16, LEN0=4, LEN1=3, ROM model 1-cycle latency)
//   T1 reset mid-PLAY: drop rst_n -> same-cycle fullnote=0, rom_addr=0, playing=0.
//   T2 song0 {34,39,41,0}, tempo=0, loop_en=0, play_p -> each note held 16 cycles,
//      steps 18 cycles apart, done_p one cycle after 4th step, then IDLE.
//   T3 tempo=2 -> PLAY 4 cycles per note; loop_en=1 -> addr 3 -> 0 wraps, no done_p.
//   T4 play_p at counter==7 -> fullnote=0, addr held; play_p again -> note restored,
//      expiry exactly 8 cycles later.
//   T5 play_p and stop_p same cycle in PLAY -> IDLE, fullnote=0, no PAUSE.
//   T6 song_sel=1 at start, toggle to 0 mid-song -> all 3 notes from rom_note1.

Source files
------------

// File: rtl/song_sequencer.sv
// Steps the note-ROM address at a programmable tempo, with play/pause/stop/loop control.
// Each note takes 2 fetch cycles plus TICK_DIV>>tempo play cycles; no backpressure, all pulses act immediately.
module song_sequencer #(
  parameter int unsigned TICK_DIV = 8388608,
  parameter int unsigned LEN0     = 196,
  parameter int unsigned LEN1     = 243,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NOTE_W   = 8
) (
  input  logic              CLK100MHZ,
  input  logic              rst_n,
  input  logic              play_p,
  input  logic              stop_p,
  input  logic              song_sel,
  input  logic              loop_en,
  input  logic [1:0]        tempo,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note0,
  input  logic [NOTE_W-1:0] rom_note1,
  output logic [NOTE_W-1:0] fullnote,
  output logic              playing,
  output logic              paused,
  output logic              done_p
);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, PAUSE, DONE} state_t;

  localparam logic [31:0]       TICK  = 32'(TICK_DIV);
  localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
  localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);

  state_t            state;
  logic              cur_song;
  logic              fetch_ph;
  logic              pause_pend;
  logic [31:0]       counter;
  logic [NOTE_W-1:0] held_note;

  logic [31:0]       period_m1;
  logic [ADDR_W-1:0] last_addr;
  logic [NOTE_W-1:0] rom_note;

  assign period_m1 = (TICK >> tempo) - 32'd1;
  assign last_addr = cur_song ? LAST1 : LAST0;
  assign rom_note  = cur_song ? rom_note1 : rom_note0;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      fullnote   <= '0;
      playing    <= 1'b0;
      paused     <= 1'b0;
      done_p     <= 1'b0;
      cur_song   <= 1'b0;
      fetch_ph   <= 1'b0;
      pause_pend <= 1'b0;
      counter    <= '0;
      held_note  <= '0;
    end else begin
      done_p <= 1'b0;
      if (stop_p) begin
        state      <= IDLE;
        rom_addr   <= '0;
        fullnote   <= '0;
        playing    <= 1'b0;
        paused     <= 1'b0;
        fetch_ph   <= 1'b0;
        pause_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            fullnote <= '0;
            if (play_p) begin
              cur_song   <= song_sel;
              rom_addr   <= '0;
              fetch_ph   <= 1'b0;
              pause_pend <= 1'b0;
              playing    <= 1'b1;
              state      <= FETCH;
            end
          end
          FETCH: begin
            if (!fetch_ph) begin
              fetch_ph <= 1'b1;
              if (play_p) pause_pend <= 1'b1;
            end else begin
              // ROM data is valid now; a pause request still latches the note first
              fetch_ph   <= 1'b0;
              pause_pend <= 1'b0;
              held_note  <= rom_note;
              counter    <= period_m1;
              if (pause_pend || play_p) begin
                fullnote <= '0;
                playing  <= 1'b0;
                paused   <= 1'b1;
                state    <= PAUSE;
              end else begin
                fullnote <= rom_note;
                state    <= PLAY;
              end
            end
          end
          PLAY: begin
            if (play_p) begin
              fullnote <= '0;
              playing  <= 1'b0;
              paused   <= 1'b1;
              state    <= PAUSE;
            end else if (counter == 32'd0) begin
              if (rom_addr != last_addr) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= FETCH;
              end else if (loop_en) begin
                rom_addr <= '0;
                state    <= FETCH;
              end else begin
                fullnote <= '0;
                playing  <= 1'b0;
                done_p   <= 1'b1;
                state    <= DONE;
              end
            end else begin
              counter <= counter - 32'd1;
            end
          end
          PAUSE: begin
            if (play_p) begin
              fullnote <= held_note;
              playing  <= 1'b1;
              paused   <= 1'b0;
              state    <= PLAY;
            end
          end
          DONE: begin
            fullnote <= '0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with small tempo/lengths; expected outputs come from a
// closed-form timeline of note steps against a 1-cycle-latency ROM model.
module tb_song_sequencer;
  localparam int TD = 16;
  localparam int L0 = 4;
  localparam int L1 = 3;

  logic       CLK100MHZ = 1'b0;
  logic       rst_n     = 1'b0;
  logic       play_p    = 1'b0;
  logic       stop_p    = 1'b0;
  logic       song_sel  = 1'b0;
  logic       loop_en   = 1'b0;
  logic [1:0] tempo     = 2'd0;
  logic [7:0] rom_addr, rom_note0, rom_note1, fullnote;
  logic       playing, paused, done_p;

  logic [7:0] rom0 [256];
  logic [7:0] rom1 [256];

  int vec  = 0;
  int errs = 0;

  song_sequencer #(.TICK_DIV(TD), .LEN0(L0), .LEN1(L1), .ADDR_W(8), .NOTE_W(8)) dut (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n), .play_p(play_p), .stop_p(stop_p),
    .song_sel(song_sel), .loop_en(loop_en), .tempo(tempo), .rom_addr(rom_addr),
    .rom_note0(rom_note0), .rom_note1(rom_note1), .fullnote(fullnote),
    .playing(playing), .paused(paused), .done_p(done_p)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(posedge CLK100MHZ) begin
    rom_note0 <= rom0[rom_addr];
    rom_note1 <= rom1[rom_addr];
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic logic [7:0] note(input bit s, input int i);
    return s ? rom1[i] : rom0[i];
  endfunction

  task automatic start_song(input bit s, input logic [1:0] tp, input bit lp);
    song_sel = s; tempo = tp; loop_en = lp;
    play_p = 1'b1; tick(); play_p = 1'b0;
  endtask

  task automatic stop_song();
    stop_p = 1'b1; tick(); stop_p = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vec++; if (fullnote !== 8'd0 || rom_addr !== 8'd0 || playing !== 1'b0 || paused !== 1'b0 || done_p !== 1'b0) begin
      errs++; $display("FAIL reset_state: note=%0d addr=%0d play=%b pause=%b done=%b, want all 0", fullnote, rom_addr, playing, paused, done_p);
    end
    rst_n = 1'b1;
    tick();
    rom0[0] = 8'd55;
    start_song(1'b0, 2'd0, 1'b0);
    repeat (8) tick();
    vec++; if (fullnote !== 8'd55 || playing !== 1'b1) begin
      errs++; $display("FAIL pre_reset_play: note=%0d play=%b, want 55/1", fullnote, playing);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (fullnote !== 8'd0 || rom_addr !== 8'd0 || playing !== 1'b0) begin
      errs++; $display("FAIL async_reset: note=%0d addr=%0d play=%b, want 0/0/0", fullnote, rom_addr, playing);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vec++; if (fullnote !== 8'd0 || playing !== 1'b0 || paused !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle: note=%0d play=%b pause=%b", fullnote, playing, paused);
    end
  endtask

  task automatic test_songs();
    for (int it = 0; it < 10; it++) begin
      bit s, lp;
      logic [1:0] tp;
      int P, L, jd, ncyc, m;
      logic [7:0] en, ea;
      bit ed, epl;
      if (it >= 3) for (int i = 0; i < 256; i++) begin rom0[i] = 8'($urandom); rom1[i] = 8'($urandom); end
      case (it)
        0: begin s = 0; tp = 0; lp = 0; rom0[0] = 34; rom0[1] = 39; rom0[2] = 41; rom0[3] = 0; end
        1: begin s = 0; tp = 2; lp = 1; end
        2: begin s = 1; tp = 1; lp = 0; end
        default: begin s = 1'($urandom); tp = 2'($urandom); lp = 1'($urandom); end
      endcase
      P = TD >> tp;
      L = s ? L1 : L0;
      jd = L * (P + 2);
      ncyc = lp ? 2 + (L + 1) * (P + 2) : jd + 1;
      start_song(s, tp, lp);
      for (int j = 0; j <= ncyc; j++) begin
        m = j - 2;
        if (lp) begin
          en  = (j < 2) ? 8'd0 : note(s, (m / (P + 2)) % L);
          ea  = 8'((j / (P + 2)) % L);
          ed  = 0;
          epl = 1;
        end else begin
          en  = (j < 2 || j >= jd) ? 8'd0 : note(s, m / (P + 2));
          ea  = 8'(((j / (P + 2)) < L) ? (j / (P + 2)) : L - 1);
          ed  = (j == jd);
          epl = (j < jd);
        end
        vec++; if (fullnote !== en) begin
          errs++; $display("FAIL note it=%0d j=%0d: got %0d want %0d", it, j, fullnote, en);
        end
        vec++; if (rom_addr !== ea) begin
          errs++; $display("FAIL addr it=%0d j=%0d: got %0d want %0d", it, j, rom_addr, ea);
        end
        vec++; if (done_p !== ed || playing !== epl || paused !== 1'b0) begin
          errs++; $display("FAIL flags it=%0d j=%0d: done=%b play=%b pause=%b want %b %b 0", it, j, done_p, playing, paused, ed, epl);
        end
        song_sel = 1'($urandom);
        if (j < ncyc) tick();
      end
      if (lp) begin
        stop_song();
        vec++; if (fullnote !== 8'd0 || rom_addr !== 8'd0 || playing !== 1'b0 || done_p !== 1'b0) begin
          errs++; $display("FAIL loop_stop it=%0d: note=%0d addr=%0d play=%b done=%b", it, fullnote, rom_addr, playing, done_p);
        end
      end
    end
  endtask

  task automatic test_pause();
    int r;
    for (int i = 0; i < 8; i++) rom0[i] = 8'($urandom_range(1, 255));
    // pause at counter==7, then resume: expiry 8 cycles later
    start_song(1'b0, 2'd0, 1'b0);
    repeat (10) tick();
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (fullnote !== 8'd0 || paused !== 1'b1 || playing !== 1'b0 || rom_addr !== 8'd0) begin
      errs++; $display("FAIL pause_enter: note=%0d pause=%b play=%b addr=%0d", fullnote, paused, playing, rom_addr);
    end
    r = $urandom_range(3, 20);
    repeat (r) tick();
    vec++; if (fullnote !== 8'd0 || rom_addr !== 8'd0 || paused !== 1'b1) begin
      errs++; $display("FAIL pause_hold: note=%0d addr=%0d pause=%b", fullnote, rom_addr, paused);
    end
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (fullnote !== rom0[0] || playing !== 1'b1 || paused !== 1'b0) begin
      errs++; $display("FAIL resume: note=%0d play=%b pause=%b want %0d 1 0", fullnote, playing, paused, rom0[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++; if (rom_addr !== ((k == 8) ? 8'd1 : 8'd0)) begin
        errs++; $display("FAIL resume_expiry k=%0d: addr=%0d", k, rom_addr);
      end
    end
    tick(); tick();
    vec++; if (fullnote !== rom0[1]) begin
      errs++; $display("FAIL next_note: got %0d want %0d", fullnote, rom0[1]);
    end
    stop_song();
    // pause requested during FETCH: read completes, then PAUSE
    start_song(1'b0, 2'd0, 1'b0);
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (playing !== 1'b1 || paused !== 1'b0) begin
      errs++; $display("FAIL fetch_pend: play=%b pause=%b want 1 0", playing, paused);
    end
    tick();
    vec++; if (paused !== 1'b1 || fullnote !== 8'd0 || playing !== 1'b0) begin
      errs++; $display("FAIL fetch_pause: pause=%b note=%0d play=%b", paused, fullnote, playing);
    end
    repeat ($urandom_range(2, 9)) tick();
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (fullnote !== rom0[0] || playing !== 1'b1) begin
      errs++; $display("FAIL fetch_resume: note=%0d want %0d play=%b", fullnote, rom0[0], playing);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      vec++; if (rom_addr !== ((k == 16) ? 8'd1 : 8'd0)) begin
        errs++; $display("FAIL fetch_resume_expiry k=%0d: addr=%0d", k, rom_addr);
      end
    end
    stop_song();
    // pause on the expiry cycle: no advance, expiry on first PLAY cycle after resume
    start_song(1'b0, 2'd0, 1'b0);
    repeat (17) tick();
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (paused !== 1'b1 || rom_addr !== 8'd0) begin
      errs++; $display("FAIL pause_at_zero: pause=%b addr=%0d want 1 0", paused, rom_addr);
    end
    repeat (4) tick();
    play_p = 1'b1; tick(); play_p = 1'b0;
    vec++; if (rom_addr !== 8'd0 || fullnote !== rom0[0]) begin
      errs++; $display("FAIL zero_resume: addr=%0d note=%0d want 0 %0d", rom_addr, fullnote, rom0[0]);
    end
    tick();
    vec++; if (rom_addr !== 8'd1) begin
      errs++; $display("FAIL zero_expiry: addr=%0d want 1", rom_addr);
    end
    stop_song();
  endtask

  task automatic test_stop_priority();
    start_song(1'b0, 2'd0, 1'b0);
    repeat (5) tick();
    play_p = 1'b1; stop_p = 1'b1; tick(); play_p = 1'b0; stop_p = 1'b0;
    vec++; if (fullnote !== 8'd0 || rom_addr !== 8'd0 || playing !== 1'b0 || paused !== 1'b0) begin
      errs++; $display("FAIL stop_play_same: note=%0d addr=%0d play=%b pause=%b", fullnote, rom_addr, playing, paused);
    end
    repeat (5) tick();
    vec++; if (playing !== 1'b0 || paused !== 1'b0 || done_p !== 1'b0) begin
      errs++; $display("FAIL stop_stays_idle: play=%b pause=%b done=%b", playing, paused, done_p);
    end
    start_song(1'b1, 2'd1, 1'b1);
    repeat (6) tick();
    play_p = 1'b1; tick(); play_p = 1'b0;
    stop_song();
    vec++; if (paused !== 1'b0 || playing !== 1'b0 || rom_addr !== 8'd0 || done_p !== 1'b0) begin
      errs++; $display("FAIL stop_from_pause: pause=%b play=%b addr=%0d done=%b", paused, playing, rom_addr, done_p);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin rom0[i] = 8'($urandom); rom1[i] = 8'($urandom); end
    test_reset();
    test_songs();
    test_pause();
    test_stop_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
